// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and receiver state encoding.
package uart_pkg;

   // The baud generator's divisor is chosen so that one bit spans this many
   // enables; keep the two in step.
   localparam int UART_OVERSAMPLE = 16;
   localparam int UART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_HIGH
   } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Bus-side view of the UART receiver: held byte, status flags and read strobe.
interface uart_rx_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS
) ();

   logic                 rd_en;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rda;
   logic                 overrun;
   logic                 frame_err;

   // Bus master issues reads; the receiver supplies data and status.
   modport master (output rd_en, input rx_data, rda, overrun, frame_err);
   modport slave  (input rd_en, output rx_data, rda, overrun, frame_err);

endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchronizer for an asynchronous level input; also intended for
// the transmitter's CTS input.
module sync2
   import uart_pkg::*;
#(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Two-stage capture; resets to the line's idle level so no false start
   // is seen while coming out of reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receive engine, 8N1 LSB first, mid-bit sampling on the oversample
// enable. Holds one byte plus data-available / overrun / framing status.
// OVERSAMPLE must be a power of two and at least 4 so the tick counter wraps
// exactly once per bit.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     receive_baud,
   input  logic     rxd,
   uart_rx_if.slave bus
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   logic rxs;

   rx_state_t            state_q,   state_d;
   logic [TW-1:0]        tick_q,    tick_d;
   logic [BW-1:0]        bit_q,     bit_d;
   logic [DATA_BITS-1:0] shift_q,   shift_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rda_q,     rda_d;
   logic                 ovr_q,     ovr_d;
   logic                 fe_q,      fe_d;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rxd),
      .q_o   (rxs)
   );

   // Next-state: frame sequencing and status updates. A read clears status
   // first, so a completion or framing error in the same cycle overrides it.
   always_comb begin
      state_d   = state_q;
      tick_d    = tick_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      rx_data_d = rx_data_q;
      rda_d     = rda_q;
      ovr_d     = ovr_q;
      fe_d      = fe_q;

      if (bus.rd_en) begin
         rda_d = 1'b0;
         ovr_d = 1'b0;
         fe_d  = 1'b0;
      end

      if (receive_baud) tick_d = tick_q + 1'b1;

      case (state_q)
         IDLE: begin
            tick_d = '0;
            if (receive_baud && !rxs) state_d = START;
         end
         START: begin
            if (receive_baud && tick_q == TICK_MID) begin
               if (!rxs) begin
                  tick_d  = '0;
                  bit_d   = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;   // glitch shorter than half a bit
               end
            end
         end
         DATA: begin
            if (receive_baud && tick_q == TICK_LAST) begin
               shift_d = {rxs, shift_q[DATA_BITS-1:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == BIT_LAST) state_d = STOP;
            end
         end
         STOP: begin
            if (receive_baud && tick_q == TICK_LAST) begin
               if (rxs) begin
                  rx_data_d = shift_q;
                  rda_d     = 1'b1;
                  if (rda_q && !bus.rd_en) ovr_d = 1'b1;
                  state_d   = IDLE;
               end else begin
                  fe_d    = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            // Not baud-gated: leave as soon as a break ends.
            if (rxs) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and status registers; reset abandons any frame in flight.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_data_q <= '0;
         rda_q     <= 1'b0;
         ovr_q     <= 1'b0;
         fe_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         tick_q    <= tick_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         rx_data_q <= rx_data_d;
         rda_q     <= rda_d;
         ovr_q     <= ovr_d;
         fe_q      <= fe_d;
      end
   end

   assign bus.rx_data   = rx_data_q;
   assign bus.rda       = rda_q;
   assign bus.overrun   = ovr_q;
   assign bus.frame_err = fe_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receive engine for the minilab serial port: 8N1, LSB first.
- Consumes the one-cycle `receive_baud` enable from the baud generator, which pulses at 16x the bit rate. Every bit-timing decision is made on that enable only.
- Synchronizes the asynchronous `rxd` line and recovers each byte by mid-bit sampling.
- Holds the byte for the bus interface, with data-available, overrun and framing-error status.

Parameters:
- OVERSAMPLE, 16, baud enables per bit period; must be a power of two, at least 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, active-low, synchronous
- receive_baud  input  1  single-cycle oversample enable from the baud generator
- rxd  input  1  asynchronous serial line, idles high
- rd_en  input  1  bus read strobe; acknowledges the held byte
- rx_data  output  DATA_BITS  last good received byte
- rda  output  1  receive data available
- overrun  output  1  sticky: a good byte completed while rda=1
- frame_err  output  1  sticky: stop bit sampled low

Behaviour:
- Reset and clocking
  - One clock. Reset is synchronous and active-low: the block resets on a clk edge while rst_n=0.
  - Reset values: rx_data=0, rda=0, overrun=0, frame_err=0, state=IDLE, tick counter=0, bit counter=0.
  - The synchronizer flops reset to 1.
  - Reset asserted mid-frame abandons the frame immediately; no status is updated.
- Line synchronization
  - rxd passes through a 2-flop synchronizer; only its output rxs is used.
- Tick counter
  - log2(OVERSAMPLE) bits wide.
  - Advances only when receive_baud=1.
  - Wraps naturally.
- State machine (all transitions are qualified by receive_baud=1 unless stated otherwise):
  - IDLE: tick counter is held at 0. If rxs=0, go to START.
  - START: when the tick counter reaches OVERSAMPLE/2-1, i.e. mid start bit:
    - if rxs=0, clear the tick counter and go to DATA with bit counter=0;
    - otherwise it is a false start; go to IDLE.
  - DATA: when the tick counter reaches OVERSAMPLE-1, i.e. mid bit:
    - shift rxs into the MSB of the shift register (right shift, so LSB-first data ends up aligned);
    - increment the bit counter;
    - after DATA_BITS samples, go to STOP.
  - STOP: when the tick counter reaches OVERSAMPLE-1, i.e. mid stop bit:
    - if rxs=1, rx_data <= shift register and rda <= 1. If rda was already 1 and rd_en is not asserted in that same cycle, set overrun. Go to IDLE.
    - if rxs=0, set frame_err; rx_data and rda are unchanged. Go to WAIT_HIGH.
  - WAIT_HIGH: go to IDLE once rxs=1. This transition is not gated by receive_baud; it prevents a break condition being taken as repeated starts.
- Status
  - rda, overrun and frame_err are all registered; they rise on the clk edge after the mid-stop sample.
  - rd_en=1 clears rda, overrun and frame_err.
  - If rd_en and a good-byte completion occur in the same cycle, the completion wins: rda stays 1, rx_data takes the new byte, overrun is cleared (not set).
  - If rd_en and a frame error occur in the same cycle, frame_err ends at 1.
- Timing and limits
  - rd_en while rda=0 is harmless.
  - Latency: the byte is available about 9.5 bit periods after the start edge, plus 2-3 clk for synchronization.
  - Back-to-back frames are supported: returning to IDLE at mid-stop leaves half a bit of margin.
  - A change to the baud divisor mid-frame is outside the contract; it corrupts only the current frame.
  - There is no parity and no FIFO; the depth is one byte.

Decomposition:
- Shared package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, STOP, WAIT_HIGH};
  - constants UART_OVERSAMPLE=16 and UART_DATA_BITS=8, which the baud generator's divisor comment also relies on.
- One natural sub-module: sync2, the 2-flop synchronizer, reusable by the transmitter's CTS input later.
- The rest is a single always_ff block plus next-state logic.

Test Plan:
- Setup for all scenarios: receive_baud pulses every 4 clk (divisor 3), so 1 bit = 64 clk.
- Reset and idle: hold rst_n=0 for 3 clk with rxd=1, then release and wait 2000 clk. rda, overrun and frame_err stay 0; rx_data=0x00.
- Good byte: frame for 0xA5, i.e. start 0, then 1,0,1,0,0,1,0,1, then stop 1.
  - rda rises between 600 and 625 clk after the start edge; rx_data=0xA5.
  - rd_en for 1 clk clears rda.
- Glitch: rxd low for 16 clk, which is shorter than half a bit. The FSM returns to IDLE; rda stays 0.
- Overrun and collision:
  - Send 0x3C then 0xC3 back-to-back with no read. Expect rx_data=0xC3, rda=1, overrun=1.
  - Repeat with rd_en asserted exactly in the second byte's completion cycle. Expect rda=1, overrun=0.
- Framing and break:
  - Send 0x55 with stop bit 0. Expect frame_err=1, rda=0, rx_data unchanged.
  - Hold rxd low for another 500 clk. There is no further status change.
  - Raise rxd and send 0x81. Expect rx_data=0x81.
- Mid-frame reset: assert rst_n=0 during bit 4 of a frame. All outputs are 0 on the next edge. The following clean frame 0x0F is received correctly.
